dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder that serves load/store requests from the MEM stage of the 16-bit pipeline. It latches a request, holds the pipeline with `stall` for a fixed, parameterised latency, and then completes the access with a one-cycle `done` pulse. On that pulse, read data is presented for capture into MEM/WB. Misaligned requests are rejected with a one-cycle `err` pulse, and no access is made.

## Interface
Parameters:
- `DATA_WIDTH`, 16: word width.
- `ADDR_WIDTH`, 8: word-index width; the array holds 2^ADDR_WIDTH words.
- `LATENCY`, 2: number of WAIT cycles per access; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `req_rd`  in  1  load request from the MEM stage.
- `req_wr`  in  1  store request from the MEM stage.
- `req_addr`  in  16  byte address.
- `req_wdata`  in  DATA_WIDTH  store data.
- `stall`  out  1  hold the pipeline; an access is being accepted or is in progress.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  DATA_WIDTH  load result; valid when `done`=1 for a load.
- `err`  out  1  one-cycle pulse: misaligned address or `req_rd`&`req_wr`.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP. Registers: state, 4-bit wait counter, latched op/index/wdata, `done`, `err`, `rdata`.
- A request is valid when exactly one of `req_rd`/`req_wr` is 1 and `req_addr[0]`=0.
- Word index = `req_addr[ADDR_WIDTH:1]`. Upper address bits are ignored, so addresses wrap modulo 2^(ADDR_WIDTH+1) bytes.
- **IDLE**
  - Valid request: latch op, index and wdata; load counter with LATENCY; go to WAIT.
  - Invalid request (misaligned, or both strobes set): register `err`=1 for the next cycle, stay in IDLE, no memory access.
  - No request: stay in IDLE.
- **WAIT**
  - Decrement the counter each cycle; inputs are ignored.
  - When the counter reaches 1, go to RESP.
  - On that same edge: a store writes latched wdata to mem[index]; a load registers mem[index] into `rdata` and sets `done`.
- **RESP**
  - `done`=1 for exactly this cycle; return to IDLE.
  - Requests presented in RESP are ignored. This is the same request the initiator held while stalled.
- `stall` = (IDLE & valid request) | WAIT. It is combinational, so the initiator sees the stall in the same cycle it presents the request.
- `rdata` holds its last load value until the next load completes; stores do not change it.
- Memory contents are not reset. Everything else resets.

## Timing
- Reset values: state IDLE, counter 0, `stall`=0, `done`=0, `err`=0, `rdata`=0, `busy`=0.
- Reset asserted mid-access returns the FSM to IDLE immediately; a pending store is dropped (memory unchanged).
- Request presented in cycle T (IDLE):
  - `stall`=1 in cycles T..T+LATENCY.
  - `done`=1 in cycle T+LATENCY+1, with `stall`=0 in that cycle.
  - Total occupancy is LATENCY+2 cycles. With the default, done arrives 3 cycles after the request.
- Back-to-back accesses: the next request is accepted in cycle T+LATENCY+2 (IDLE). It is never accepted during RESP.
- A store becomes visible to a load accepted in any later cycle.
- `err` appears in the cycle after the bad request; `stall` stays 0 for bad requests.
- `busy` is 1 in WAIT and RESP.

## Test plan
- **Reset:** drive `rst`=0 mid-WAIT of a store of 0xBEEF to 0x0010 → all outputs 0 immediately. After release, a load from 0x0010 does not return 0xBEEF.
- **Store/load, LATENCY=2:**
  - Store 0x1234 to 0x0004 at T → `stall` high in T..T+2, `done` at T+3, `rdata` unchanged.
  - Load 0x0004 → `done` with `rdata`=0x1234, 3 cycles after the request.
- **Misaligned and conflicting requests:**
  - Load from 0x0005 → `err`=1 next cycle, `stall`=0, `busy`=0.
  - `req_rd`=`req_wr`=1 → same response; memory unchanged.
- **Address wrap, ADDR_WIDTH=8:** store 0xAAAA to 0x0202, then load 0x0002 → `rdata`=0xAAAA.
- **Held request:** hold the load request asserted through RESP → exactly one `done` pulse. With the request still held, it is accepted as a fresh access in the following IDLE cycle.
- **LATENCY=1 and LATENCY=15 builds:** `done` arrives at T+2 and T+16 respectively; `stall` covers exactly LATENCY+1 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//   Multi-cycle data-memory responder for the MEM stage of the 16-bit
//   pipeline. A valid load/store is latched in IDLE, the pipeline is held
//   with `stall` for LATENCY wait cycles, and the access completes with a
//   one-cycle `done` pulse (load data on `rdata`). Misaligned requests or
//   requests with both strobes set produce a one-cycle `err` pulse and make
//   no memory access.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   req_rd     in   load request
//   req_wr     in   store request
//   req_addr   in   byte address (word index = req_addr[ADDR_WIDTH:1])
//   req_wdata  in   store data
//   stall      out  request being accepted (IDLE) or access in progress (WAIT)
//   done       out  one-cycle completion pulse
//   rdata      out  last load result, valid with `done` for a load
//   err        out  one-cycle pulse after a misaligned/conflicting request
//   busy       out  FSM not in IDLE
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_rd,
    input  logic                  req_wr,
    input  logic [15:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    op_wr_q, op_wr_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    mem_we;

    logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

    logic                    req_any;
    logic                    req_valid;
    logic                    addr_unused;

    assign req_any     = req_rd | req_wr;
    assign req_valid   = (req_rd ^ req_wr) & ~req_addr[0];
    // Address bits above the word index are deliberately ignored (wrap).
    assign addr_unused = ^req_addr[15:ADDR_WIDTH+1];

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_WAIT;
                    cnt_d   = LAT_INIT;
                    op_wr_d = req_wr;
                    idx_d   = req_addr[ADDR_WIDTH:1];
                    wdata_d = req_wdata;
                end else if (req_any) begin
                    err_d = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // The access itself happens on the edge leaving WAIT, so
                // `done` and load data appear together in RESP.
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    done_d  = 1'b1;
                    if (op_wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem[idx_q];
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Storage array is not reset. The write enable is derived from state_q,
    // which is forced to IDLE by reset, so a pending store is dropped.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Gated by reset so an initiator still holding its request during
    // reset does not see a stall.
    assign stall = rst & (((state_q == S_IDLE) & req_valid) | (state_q == S_WAIT));
    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
//   Self-checking bench for dmem_responder. Three instances share clock and
//   reset: LATENCY=2 (main), LATENCY=1 and LATENCY=15. Directed vectors come
//   from a table; randomized transactions are checked against a word-array
//   model of memory plus cycle-offset timing rules.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd    [3];
    logic        wr    [3];
    logic [15:0] addr  [3];
    logic [15:0] wdata [3];
    logic        stall [3];
    logic        done  [3];
    logic        err   [3];
    logic        busy  [3];
    logic [15:0] rdata [3];

    int unsigned lat [3] = '{2, 1, 15};

    int nerr = 0;
    int nchk = 0;

    dmem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst), .req_rd(rd[0]), .req_wr(wr[0]),
        .req_addr(addr[0]), .req_wdata(wdata[0]), .stall(stall[0]),
        .done(done[0]), .rdata(rdata[0]), .err(err[0]), .busy(busy[0]));

    dmem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_rd(rd[1]), .req_wr(wr[1]),
        .req_addr(addr[1]), .req_wdata(wdata[1]), .stall(stall[1]),
        .done(done[1]), .rdata(rdata[1]), .err(err[1]), .busy(busy[1]));

    dmem_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .LATENCY(15)) u_dut2 (
        .clk(clk), .rst(rst), .req_rd(rd[2]), .req_wr(wr[2]),
        .req_addr(addr[2]), .req_wdata(wdata[2]), .stall(stall[2]),
        .done(done[2]), .rdata(rdata[2]), .err(err[2]), .busy(busy[2]));

    typedef struct {
        logic        r;
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        logic        bad;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t tbl [10];

    // Reference memory model
    logic [15:0] mm      [3][256];
    bit          wrote   [3][256];
    logic [15:0] last    [3];
    bit          last_ok [3];

    task automatic chk(input string name, input int k,
                       input logic [15:0] act, input logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s (dut%0d): got %h expected %h", name, k, act, exp);
        end
    endtask

    task automatic set_req(input int k, input logic r, input logic w,
                           input logic [15:0] a, input logic [15:0] d);
        rd[k]    = r;
        wr[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
    endtask

    task automatic clr_req(input int k);
        set_req(k, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One access starting in an IDLE cycle. Checks stall/busy/done/err on
    // every cycle up to and including RESP (or the err cycle for a bad
    // request). With hold=1 the request stays asserted through RESP and is
    // left asserted on return.
    task automatic txn(input int k, input string tag,
                       input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] d,
                       input logic hold, input logic bad,
                       input logic chk_rd, input logic [15:0] exp_rd);
        int unsigned L;
        L = lat[k];
        set_req(k, r, w, a, d);
        @(negedge clk);
        chk({tag, " stall@req"}, k, 16'(stall[k]), 16'(!bad));
        chk({tag, " busy@req"},  k, 16'(busy[k]),  16'h0);
        chk({tag, " done@req"},  k, 16'(done[k]),  16'h0);
        step();
        if (bad) begin
            if (!hold) clr_req(k);
            @(negedge clk);
            chk({tag, " err"},        k, 16'(err[k]),   16'h1);
            chk({tag, " stall@err"},  k, 16'(stall[k]), 16'h0);
            chk({tag, " busy@err"},   k, 16'(busy[k]),  16'h0);
            chk({tag, " done@err"},   k, 16'(done[k]),  16'h0);
            step();
            return;
        end
        for (int unsigned i = 1; i <= L + 1; i++) begin
            if (i == 1 && !hold) clr_req(k);
            @(negedge clk);
            chk({tag, " stall"}, k, 16'(stall[k]), 16'(i <= L));
            chk({tag, " done"},  k, 16'(done[k]),  16'(i == L + 1));
            chk({tag, " busy"},  k, 16'(busy[k]),  16'h1);
            chk({tag, " err"},   k, 16'(err[k]),   16'h0);
            if (i == L + 1 && chk_rd) chk({tag, " rdata"}, k, rdata[k], exp_rd);
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned ix;
        int unsigned kind;
        int          k;
        logic [15:0] a;
        logic [15:0] d;
        logic        h;

        tbl[0] = '{1'b0, 1'b1, 16'h0004, 16'h1234, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'h1234};
        tbl[2] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'h0000};
        tbl[3] = '{1'b1, 1'b1, 16'h0004, 16'hFFFF, 1'b1, 16'h0000};
        tbl[4] = '{1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'h1234};
        tbl[5] = '{1'b0, 1'b1, 16'h0202, 16'hAAAA, 1'b0, 16'h1234};
        tbl[6] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'hAAAA};
        tbl[7] = '{1'b0, 1'b1, 16'h0006, 16'h5A5A, 1'b0, 16'hAAAA};
        tbl[8] = '{1'b0, 1'b1, 16'h0007, 16'hDEAD, 1'b1, 16'h0000};
        tbl[9] = '{1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0, 16'h5A5A};

        // Reset with a request held on dut0: everything must read zero.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) clr_req(i);
        set_req(0, 1'b1, 1'b0, 16'h0004, 16'h0000);
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("reset stall", i, 16'(stall[i]), 16'h0);
            chk("reset done",  i, 16'(done[i]),  16'h0);
            chk("reset err",   i, 16'(err[i]),   16'h0);
            chk("reset busy",  i, 16'(busy[i]),  16'h0);
            chk("reset rdata", i, rdata[i],      16'h0000);
        end
        clr_req(0);
        #1 rst = 1'b1;
        step();

        // Directed vectors on the LATENCY=2 instance.
        for (int i = 0; i < 10; i++) begin
            txn(0, $sformatf("vec%0d", i), tbl[i].r, tbl[i].w, tbl[i].a,
                tbl[i].d, 1'b0, tbl[i].bad, !tbl[i].bad, tbl[i].exp_rd);
        end

        // Load held through RESP: one done, then re-accepted in next IDLE.
        txn(0, "held1", 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1234);
        txn(0, "held2", 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234);

        // Reset in the middle of a store's WAIT phase drops the store.
        txn(0, "prestore", 1'b0, 1'b1, 16'h0010, 16'h5555, 1'b0, 1'b0, 1'b1, 16'h1234);
        set_req(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF);
        @(negedge clk);
        chk("midrst stall@req", 0, 16'(stall[0]), 16'h1);
        step();
        #1 rst = 1'b0;
        #1;
        chk("midrst stall", 0, 16'(stall[0]), 16'h0);
        chk("midrst done",  0, 16'(done[0]),  16'h0);
        chk("midrst err",   0, 16'(err[0]),   16'h0);
        chk("midrst busy",  0, 16'(busy[0]),  16'h0);
        chk("midrst rdata", 0, rdata[0],      16'h0000);
        step();
        step();
        clr_req(0);
        #2 rst = 1'b1;
        step();
        txn(0, "postrst load", 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h5555);

        // LATENCY=1 and LATENCY=15 instances.
        for (int i = 1; i < 3; i++) begin
            txn(i, "lat store", 1'b0, 1'b1, 16'h0020, 16'(16'h0F00 + i), 1'b0, 1'b0, 1'b1, 16'h0000);
            txn(i, "lat load",  1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 1'b1, 16'(16'h0F00 + i));
        end

        // Randomized accesses against the model.
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 256; j++) wrote[i][j] = 1'b0;
        last[0] = 16'h5555; last[1] = 16'h0F01; last[2] = 16'h0F02;
        for (int i = 0; i < 3; i++) last_ok[i] = 1'b1;

        for (int n = 0; n < 150; n++) begin
            k    = int'($urandom_range(0, 2));
            kind = $urandom_range(0, 9);
            a    = 16'($urandom_range(0, 127) * 512 + $urandom_range(0, 15) * 2);
            d    = 16'($urandom);
            ix   = (int'(a) / 2) % 256;
            if (kind == 0) begin
                a = a + 16'd1;
                h = ($urandom_range(0, 1) == 1);
                txn(k, "rnd misaligned", h, !h, a, d, 1'b0, 1'b1, 1'b0, 16'h0000);
            end else if (kind == 1) begin
                txn(k, "rnd both", 1'b1, 1'b1, a, d, 1'b0, 1'b1, 1'b0, 16'h0000);
            end else if (kind < 6) begin
                h = ($urandom_range(0, 3) == 0);
                txn(k, "rnd store", 1'b0, 1'b1, a, d, h, 1'b0, last_ok[k], last[k]);
                mm[k][ix]    = d;
                wrote[k][ix] = 1'b1;
            end else begin
                h = ($urandom_range(0, 3) == 0);
                txn(k, "rnd load", 1'b1, 1'b0, a, d, h, 1'b0, wrote[k][ix], mm[k][ix]);
                last[k]    = mm[k][ix];
                last_ok[k] = wrote[k][ix];
            end
            clr_req(k);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
